ram_arbiter: RTL and testbench

- Shares the single-ported simulation RAM model (RAMHelper: word-indexed, 64-bit, bit-masked write, read data returned at the clock edge) between two requesters.
  - imem: instruction fetch, read-only.
  - dmem: load/store, read or write.
- Each requester side uses valid/ready request and response channels.
- Requesters are chosen round-robin; one transaction is in flight at a time.
- Sits between the core's memory ports and the RAMHelper instance in the simulation top.

---
 rtl/ram_arb_pkg.sv | 29 ++
 rtl/ram_arb_rr2.sv | 30 +++
 rtl/ram_arbiter.sv | 135 +++++++++++++
 tb/tb_ram_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the two-requester RAMHelper arbiter.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_e;

    typedef enum logic {
        IMEM = 1'b0,
        DMEM = 1'b1
    } port_e;

    localparam logic [63:0] RAM_BASE_DEF  = 64'h8000_0000;
    localparam int          IDX_SHIFT_DEF = 3;

    // Byte strobe i covers mask bits [8i+7:8i].
    function automatic logic [63:0] strb2mask(input logic [7:0] strb);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < 8; i++) begin
            m[8*i +: 8] = {8{strb[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/ram_arb_rr2.sv
// Two-way round-robin picker; the priority bit is owned here and moves away
// from whichever port was granted.
module ram_arb_rr2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] valid_i,
    input  logic       advance_i,
    output logic [1:0] gnt_o,
    output logic       prio_o
);
    logic prio_q;

    always_comb begin
        gnt_o = valid_i;
        if (valid_i == 2'b11) begin
            gnt_o = prio_q ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q <= 1'b0;
        end else if (advance_i) begin
            prio_q <= gnt_o[0];
        end
    end

    assign prio_o = prio_q;

endmodule

// File: rtl/ram_arbiter.sv
// Shares one RAMHelper between instruction fetch and load/store, one
// transaction at a time: IDLE -> ISSUE -> CAPTURE -> RESP.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter logic [63:0] RAM_BASE  = RAM_BASE_DEF,
    parameter int          IDX_SHIFT = IDX_SHIFT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        imem_req_valid,
    output logic        imem_req_ready,
    input  logic [63:0] imem_req_addr,
    output logic        imem_resp_valid,
    input  logic        imem_resp_ready,
    output logic [63:0] imem_resp_rdata,
    input  logic        dmem_req_valid,
    output logic        dmem_req_ready,
    input  logic [63:0] dmem_req_addr,
    input  logic        dmem_req_wen,
    input  logic [63:0] dmem_req_wdata,
    input  logic [7:0]  dmem_req_wstrb,
    output logic        dmem_resp_valid,
    input  logic        dmem_resp_ready,
    output logic [63:0] dmem_resp_rdata,
    output logic [63:0] ram_ridx,
    input  logic [63:0] ram_rdata,
    output logic [63:0] ram_widx,
    output logic [63:0] ram_wdata,
    output logic [63:0] ram_wmask,
    output logic        ram_wen
);
    state_e      state_q, state_d;
    port_e       port_q, port_d;
    logic [63:0] idx_q, idx_d;
    logic        wen_q, wen_d;
    logic [63:0] wdata_q, wdata_d;
    logic [63:0] mask_q, mask_d;
    logic [63:0] rdata_q, rdata_d;

    logic [1:0]  gnt;
    logic        accept;
    logic        prio;
    logic [63:0] sel_addr;

    ram_arb_rr2 u_rr (
        .clk       (clk),
        .reset     (reset),
        .valid_i   ({dmem_req_valid, imem_req_valid}),
        .advance_i (accept),
        .gnt_o     (gnt),
        .prio_o    (prio)
    );

    assign sel_addr = gnt[1] ? dmem_req_addr : imem_req_addr;

    always_comb begin
        state_d         = state_q;
        port_d          = port_q;
        idx_d           = idx_q;
        wen_d           = wen_q;
        wdata_d         = wdata_q;
        mask_d          = mask_q;
        rdata_d         = rdata_q;
        imem_req_ready  = 1'b0;
        dmem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        dmem_resp_valid = 1'b0;
        accept          = 1'b0;
        ram_wen         = 1'b0;
        case (state_q)
            IDLE: begin
                imem_req_ready = gnt[0] & ~reset;
                dmem_req_ready = gnt[1] & ~reset;
                accept         = (|gnt) & ~reset;
                if (accept) begin
                    port_d  = gnt[1] ? DMEM : IMEM;
                    idx_d   = (sel_addr - RAM_BASE) >> IDX_SHIFT;
                    wen_d   = gnt[1] & dmem_req_wen;
                    wdata_d = gnt[1] ? dmem_req_wdata : '0;
                    mask_d  = gnt[1] ? strb2mask(dmem_req_wstrb) : '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // Reset landing on this cycle must not commit the write.
                ram_wen = wen_q & ~reset;
                state_d = CAPTURE;
            end
            CAPTURE: begin
                rdata_d = wen_q ? '0 : ram_rdata;
                state_d = RESP;
            end
            RESP: begin
                imem_resp_valid = (port_q == IMEM);
                dmem_resp_valid = (port_q == DMEM);
                if ((port_q == DMEM) ? dmem_resp_ready : imem_resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            port_q  <= IMEM;
            idx_q   <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            mask_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
            idx_q   <= idx_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
            rdata_q <= rdata_d;
        end
    end

    assign ram_ridx        = idx_q;
    assign ram_widx        = idx_q;
    assign ram_wdata       = wdata_q;
    assign ram_wmask       = mask_q;
    assign imem_resp_rdata = rdata_q;
    assign dmem_resp_rdata = rdata_q;

    logic unused_prio;
    assign unused_prio = prio;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a small RAMHelper model.
module tb_ram_arbiter;
    logic        clk;
    logic        reset;
    logic        imem_req_valid, imem_req_ready, imem_resp_valid, imem_resp_ready;
    logic [63:0] imem_req_addr, imem_resp_rdata;
    logic        dmem_req_valid, dmem_req_ready, dmem_req_wen, dmem_resp_valid, dmem_resp_ready;
    logic [63:0] dmem_req_addr, dmem_req_wdata, dmem_resp_rdata;
    logic [7:0]  dmem_req_wstrb;
    logic [63:0] ram_ridx, ram_rdata, ram_widx, ram_wdata, ram_wmask;
    logic        ram_wen;

    int passed = 0;
    int total  = 0;

    ram_arbiter dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_ready (imem_resp_ready),
        .imem_resp_rdata (imem_resp_rdata),
        .dmem_req_valid  (dmem_req_valid),
        .dmem_req_ready  (dmem_req_ready),
        .dmem_req_addr   (dmem_req_addr),
        .dmem_req_wen    (dmem_req_wen),
        .dmem_req_wdata  (dmem_req_wdata),
        .dmem_req_wstrb  (dmem_req_wstrb),
        .dmem_resp_valid (dmem_resp_valid),
        .dmem_resp_ready (dmem_resp_ready),
        .dmem_resp_rdata (dmem_resp_rdata),
        .ram_ridx        (ram_ridx),
        .ram_rdata       (ram_rdata),
        .ram_widx        (ram_widx),
        .ram_wdata       (ram_wdata),
        .ram_wmask       (ram_wmask),
        .ram_wen         (ram_wen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAMHelper model: registered read, masked write, read sees pre-write data.
    logic [63:0] mem [16];
    logic        pl_en;
    logic [3:0]  pl_idx;
    logic [63:0] pl_data;

    always @(posedge clk) begin
        ram_rdata <= mem[ram_ridx[3:0]];
        if (pl_en)
            mem[pl_idx] <= pl_data;
        else if (ram_wen)
            mem[ram_widx[3:0]] <= (mem[ram_widx[3:0]] & ~ram_wmask) | (ram_wdata & ram_wmask);
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic preload(input logic [3:0] idx, input logic [63:0] data);
        pl_en = 1'b1; pl_idx = idx; pl_data = data;
        nxt();
        pl_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        pl_en = 1'b0; pl_idx = '0; pl_data = '0;
        imem_req_valid = 0; imem_req_addr = '0; imem_resp_ready = 0;
        dmem_req_valid = 0; dmem_req_addr = '0; dmem_req_wen = 0;
        dmem_req_wdata = '0; dmem_req_wstrb = '0; dmem_resp_ready = 0;
        nxt();
        preload(4'd0, 64'h0BAD_F00D_0000_0001);
        preload(4'd1, 64'hAAAA_BBBB_CCCC_DDDD);
        preload(4'd2, 64'hDEAD_BEEF_0123_4567);
        preload(4'd3, 64'h3333_3333_3333_3333);
        #1;
        chk("rst_ireq_rdy", imem_req_ready, 0);
        chk("rst_dreq_rdy", dmem_req_ready, 0);
        chk("rst_iresp_vld", imem_resp_valid, 0);
        chk("rst_dresp_vld", dmem_resp_valid, 0);
        chk("rst_rdata", dmem_resp_rdata, 0);
        chk("rst_ram_wen", ram_wen, 0);
        chk("rst_ridx", ram_ridx, 0);
        chk("rst_wmask", ram_wmask, 0);
        chk("rst_wdata", ram_wdata, 0);

        // imem read of word 2
        reset = 1'b0;
        imem_req_valid = 1; imem_req_addr = 64'h8000_0010; imem_resp_ready = 1;
        #1;
        chk("t1_ireq_rdy", imem_req_ready, 1);
        chk("t1_dreq_rdy", dmem_req_ready, 0);
        nxt(); imem_req_valid = 0; #1;
        chk("t1_ridx", ram_ridx, 2);
        chk("t1_issue_wen", ram_wen, 0);
        nxt(); #1;
        chk("t1_cap_vld", imem_resp_valid, 0);
        nxt(); #1;
        chk("t1_resp_vld", imem_resp_valid, 1);
        chk("t1_resp_data", imem_resp_rdata, 64'hDEAD_BEEF_0123_4567);
        chk("t1_dresp_vld", dmem_resp_valid, 0);
        nxt(); #1;
        chk("t1_resp_drop", imem_resp_valid, 0);

        // dmem partial write of word 1, then read back
        dmem_req_valid = 1; dmem_req_addr = 64'h8000_0008; dmem_req_wen = 1;
        dmem_req_wdata = 64'h1122_3344_5566_7788; dmem_req_wstrb = 8'h0F; dmem_resp_ready = 1;
        #1;
        chk("t2_dreq_rdy", dmem_req_ready, 1);
        nxt(); dmem_req_valid = 0; #1;
        chk("t2_issue_wen", ram_wen, 1);
        chk("t2_widx", ram_widx, 1);
        chk("t2_wmask", ram_wmask, 64'h0000_0000_FFFF_FFFF);
        chk("t2_wdata", ram_wdata, 64'h1122_3344_5566_7788);
        nxt(); #1;
        chk("t2_cap_wen", ram_wen, 0);
        nxt(); #1;
        chk("t2_ack_vld", dmem_resp_valid, 1);
        chk("t2_ack_data", dmem_resp_rdata, 0);
        chk("t2_resp_wen", ram_wen, 0);
        nxt();
        dmem_req_valid = 1; dmem_req_wen = 0; #1;
        chk("t2_rd_rdy", dmem_req_ready, 1);
        nxt(); dmem_req_valid = 0;
        nxt(); nxt(); #1;
        chk("t2_rd_vld", dmem_resp_valid, 1);
        chk("t2_rd_data", dmem_resp_rdata, 64'hAAAA_BBBB_5566_7788);
        nxt();

        // both ports valid continuously: grants alternate from imem
        reset = 1; nxt(); reset = 0;
        imem_req_valid = 1; imem_req_addr = 64'h8000_0000; imem_resp_ready = 1;
        dmem_req_valid = 1; dmem_req_addr = 64'h8000_0018; dmem_req_wen = 0; dmem_resp_ready = 1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("t3_grant%0d", k), {dmem_req_ready, imem_req_ready},
                (k % 2 == 0) ? 64'd1 : 64'd2);
            for (int c = 0; c < 3; c++) begin
                nxt(); #1;
                chk($sformatf("t3_busy%0d_%0d", k, c), {dmem_req_ready, imem_req_ready}, 0);
            end
            nxt();
        end
        imem_req_valid = 0; dmem_req_valid = 0;

        // dmem response stall keeps imem out
        reset = 1; nxt(); reset = 0;
        imem_req_valid = 1; imem_req_addr = 64'h8000_0000;
        nxt(); imem_req_valid = 0;
        nxt(); nxt(); nxt();
        imem_req_valid = 1; dmem_req_valid = 1; dmem_req_addr = 64'h8000_0010;
        dmem_req_wen = 0; dmem_resp_ready = 0; #1;
        chk("t4_dgrant", {dmem_req_ready, imem_req_ready}, 2);
        nxt(); dmem_req_valid = 0;
        nxt(); nxt();
        for (int s = 0; s < 5; s++) begin
            #1;
            chk($sformatf("t4_stall_vld%0d", s), dmem_resp_valid, 1);
            chk($sformatf("t4_stall_data%0d", s), dmem_resp_rdata, 64'hDEAD_BEEF_0123_4567);
            chk($sformatf("t4_stall_irdy%0d", s), imem_req_ready, 0);
            nxt();
        end
        dmem_resp_ready = 1; #1;
        chk("t4_release_vld", dmem_resp_valid, 1);
        nxt(); #1;
        chk("t4_igrant", {dmem_req_ready, imem_req_ready}, 1);
        nxt(); imem_req_valid = 0;
        nxt(); nxt(); nxt();

        // reset during ISSUE of a write to word 3
        dmem_req_valid = 1; dmem_req_addr = 64'h8000_0018; dmem_req_wen = 1;
        dmem_req_wdata = '1; dmem_req_wstrb = 8'hFF; #1;
        chk("t5_dreq_rdy", dmem_req_ready, 1);
        nxt(); dmem_req_valid = 0; reset = 1; #1;
        chk("t5_wen_gated", ram_wen, 0);
        nxt(); reset = 0; #1;
        chk("t5_dresp_vld", dmem_resp_valid, 0);
        chk("t5_widx", ram_widx, 0);
        chk("t5_wmask", ram_wmask, 0);
        chk("t5_wdata", ram_wdata, 0);
        chk("t5_rdata", dmem_resp_rdata, 0);
        chk("t5_wen", ram_wen, 0);
        chk("t5_word3", mem[3], 64'h3333_3333_3333_3333);
        for (int c = 0; c < 4; c++) begin
            nxt(); #1;
            chk($sformatf("t5_noresp%0d", c), dmem_resp_valid | imem_resp_valid, 0);
        end
        imem_req_valid = 1; imem_req_addr = 64'h8000_0008;
        dmem_req_valid = 1; dmem_req_wen = 0; #1;
        chk("t5_first_grant", {dmem_req_ready, imem_req_ready}, 1);
        nxt(); imem_req_valid = 0; dmem_req_valid = 0;
        nxt(); nxt(); nxt();

        // misaligned and below-base addresses
        imem_req_valid = 1; imem_req_addr = 64'h8000_0007;
        nxt(); imem_req_valid = 0; #1;
        chk("t6_misalign_ridx", ram_ridx, 0);
        nxt(); nxt(); #1;
        chk("t6_misalign_data", imem_resp_rdata, 64'h0BAD_F00D_0000_0001);
        nxt();
        imem_req_valid = 1; imem_req_addr = 64'h0;
        nxt(); imem_req_valid = 0; #1;
        chk("t6_wrap_ridx", ram_ridx, 64'h1FFF_FFFF_F000_0000);
        nxt(); nxt(); nxt();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
